// File: rtl/csd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csd_decoder_pkg
// Description : Shared definitions for the CSD-to-binary decoder: digit-code
//               constants, geometry, result widths, FSM state encoding and a
//               digit-code classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package csd_decoder_pkg;

  // Digit memory geometry
  localparam int N_DIGITS = 16;
  localparam int ADDR_W   = 4;

  // Result widths: 17-bit signed value, count range 0..16
  localparam int VALUE_W  = 17;
  localparam int CNT_W    = 5;

  // Digit codes stored in the RAM
  localparam logic [7:0] CSD_ZERO = 8'h00;
  localparam logic [7:0] CSD_POS  = 8'h01;
  localparam logic [7:0] CSD_NEG  = 8'hFF;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Classification of one stored digit code
  typedef struct packed {
    logic pos;  // +1
    logic neg;  // -1
    logic bad;  // not one of the three legal codes
  } digit_t;

  // Illegal codes are reported through 'bad' and otherwise behave as zero.
  function automatic digit_t decode_digit(input logic [7:0] code);
    digit_t d;
    d.pos = (code == CSD_POS);
    d.neg = (code == CSD_NEG);
    d.bad = (code != CSD_POS) && (code != CSD_NEG) && (code != CSD_ZERO);
    return d;
  endfunction

endpackage : csd_decoder_pkg
`default_nettype wire

// File: rtl/csd_digit_ram.sv
`default_nettype none
// ============================================================================
// Module      : csd_digit_ram
// Description : 16 x 8 digit memory. Synchronous write, registered read
//               (one-cycle latency). Reset clears every entry and the read
//               register.
// Ports       : clk      - clock, rising edge
//               reset    - synchronous active-high reset
//               we       - write enable
//               address  - read/write address
//               dataIn   - write data
//               dataOut  - registered read data of previous cycle's address
// Revision    : 1.0 - initial release
// ============================================================================
module csd_digit_ram
  import csd_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        dataIn,
  output logic [7:0]        dataOut
);

  logic [7:0] r_mem [N_DIGITS];
  logic [7:0] r_dout;

  // Reset has to clear the whole array, so the storage is a register file
  // rather than a plain inferred block RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        r_mem[i] <= CSD_ZERO;
      end
      r_dout <= CSD_ZERO;
    end else begin
      if (we) begin
        r_mem[address] <= dataIn;
      end
      // Read-before-write: a write and a read to the same address in one
      // cycle returns the old contents.
      r_dout <= r_mem[address];
    end
  end

  assign dataOut = r_dout;

endmodule : csd_digit_ram
`default_nettype wire

// File: rtl/csd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : csd_decoder
// Description : Converts a 16-digit canonical-signed-digit word, held in an
//               internal digit RAM, into a 17-bit two's-complement value.
//               A start pulse scans the digits LSB-first, one per cycle, and
//               reports value, nonzero-digit count and validity flags.
// Ports       : clk        - clock, rising edge
//               reset      - synchronous active-high reset (clears RAM too)
//               start      - begin scan (accepted in IDLE only)
//               we         - digit write enable (accepted in IDLE only)
//               address    - digit position for writes
//               dataIn     - digit code: 00 = 0, 01 = +1, FF = -1
//               busy       - scan in progress
//               done       - one-cycle result-valid pulse
//               value      - signed result
//               nz_count   - number of nonzero digits
//               not_csd    - two adjacent digits both nonzero
//               err_code   - an illegal digit code was seen
//               over_limit - nz_count exceeds MAX_NZ
// Revision    : 1.0 - initial release
// ============================================================================
module csd_decoder
  import csd_decoder_pkg::*;
#(
  parameter int MAX_NZ = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         address,
  input  logic [7:0]                dataIn,
  output logic                      busy,
  output logic                      done,
  output logic signed [VALUE_W-1:0] value,
  output logic [CNT_W-1:0]          nz_count,
  output logic                      not_csd,
  output logic                      err_code,
  output logic                      over_limit
);

  // The scan counter runs one step past the last digit so that the final
  // RAM read has time to return before the FSM leaves SCAN.
  localparam logic [ADDR_W:0]  c_scan_last = (ADDR_W+1)'(N_DIGITS);
  localparam logic [CNT_W-1:0] c_max_nz    = CNT_W'(MAX_NZ);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_idx;
  logic [ADDR_W-1:0]   r_acc_idx;
  logic                r_acc_en;
  logic                r_prev_nz;
  logic [VALUE_W-1:0]  r_value;
  logic [CNT_W-1:0]    r_nz_count;
  logic                r_not_csd;
  logic                r_err_code;

  logic                w_idle;
  logic                w_scan;
  logic                w_start_ok;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [7:0]          w_rd_data;
  digit_t              w_digit;
  logic                w_nz;
  logic [VALUE_W-1:0]  w_weight;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_scan     = (r_state == ST_SCAN);
  assign w_start_ok = w_idle && start;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (r_idx == c_scan_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Scan counter and delayed accumulation index
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_acc_idx <= '0;
      r_acc_en  <= 1'b0;
    end else begin
      if (w_scan) begin
        r_idx <= r_idx + 1'b1;
      end else begin
        r_idx <= '0;
      end
      // Data for the address issued this cycle arrives next cycle, so the
      // accumulation stage trails the scan counter by one.
      r_acc_idx <= r_idx[ADDR_W-1:0];
      r_acc_en  <= w_scan && (r_idx < c_scan_last);
    end
  end

  // --------------------------------------------------------------------------
  // Digit RAM
  // --------------------------------------------------------------------------
  assign w_ram_we  = we && w_idle;
  assign w_rd_addr = w_scan ? r_idx[ADDR_W-1:0] : address;

  csd_digit_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (w_ram_we),
    .address (w_rd_addr),
    .dataIn  (dataIn),
    .dataOut (w_rd_data)
  );

  // --------------------------------------------------------------------------
  // Accumulator, counter and flags
  // --------------------------------------------------------------------------
  assign w_digit  = decode_digit(w_rd_data);
  assign w_nz     = w_digit.pos || w_digit.neg;
  assign w_weight = VALUE_W'(1) << r_acc_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value    <= '0;
      r_nz_count <= '0;
      r_not_csd  <= 1'b0;
      r_err_code <= 1'b0;
      r_prev_nz  <= 1'b0;
    end else if (w_start_ok) begin
      // Clearing r_prev_nz means digit 0 is never compared with anything.
      r_value    <= '0;
      r_nz_count <= '0;
      r_not_csd  <= 1'b0;
      r_err_code <= 1'b0;
      r_prev_nz  <= 1'b0;
    end else if (r_acc_en) begin
      if (w_digit.pos) begin
        r_value <= r_value + w_weight;
      end else if (w_digit.neg) begin
        r_value <= r_value - w_weight;
      end
      r_nz_count <= r_nz_count + CNT_W'(w_nz);
      r_not_csd  <= r_not_csd  | (r_prev_nz & w_nz);
      r_err_code <= r_err_code | w_digit.bad;
      r_prev_nz  <= w_nz;
    end
  end

  assign value      = r_value;
  assign nz_count   = r_nz_count;
  assign not_csd    = r_not_csd;
  assign err_code   = r_err_code;
  assign over_limit = (r_nz_count > c_max_nz);

endmodule : csd_decoder
`default_nettype wire

// File: tb/tb_csd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_csd_decoder
// Description : Directed self-checking bench for csd_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csd_decoder;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               we;
  logic [3:0]         address;
  logic [7:0]         dataIn;
  logic               busy;
  logic               done;
  logic signed [16:0] value;
  logic [4:0]         nz_count;
  logic               not_csd;
  logic               err_code;
  logic               over_limit;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat;

  csd_decoder #(.MAX_NZ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .we         (we),
    .address    (address),
    .dataIn     (dataIn),
    .busy       (busy),
    .done       (done),
    .value      (value),
    .nz_count   (nz_count),
    .not_csd    (not_csd),
    .err_code   (err_code),
    .over_limit (over_limit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic write_digit(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1 we = 1'b1; address = a; dataIn = d;
    @(posedge clk); #1 we = 1'b0;
  endtask

  // Pulses start (optionally with a same-cycle write), then runs until done.
  // inj   : cycle offset at which to pulse we+start mid-scan (0 = none)
  // rst_at: cycle offset at which to assert reset (0 = none)
  // On return after a normal run, the bench sits #1 into the DONE cycle.
  task automatic run_scan(input int inj, input int rst_at, input logic wr,
                          input logic [3:0] wa, input logic [7:0] wd);
    logic was_reset;
    was_reset = 1'b0;
    @(posedge clk); #1 start = 1'b1; we = wr; address = wa; dataIn = wd;
    @(posedge clk); lat = 1; #1 start = 1'b0; we = 1'b0;
    check("busy_first_scan_cycle", busy, 1);
    while (!done && !was_reset && lat < 40) begin
      if (lat == inj) begin
        we = 1'b1; address = 4'd0; dataIn = 8'hFF; start = 1'b1;
      end
      if (lat == rst_at) reset = 1'b1;
      @(posedge clk); lat++; #1;
      we = 1'b0; start = 1'b0;
      if (reset) begin
        reset = 1'b0;
        was_reset = 1'b1;
      end
    end
  endtask

  task automatic check_result(input string tag, input int v, input int nz,
                              input logic nc, input logic ec, input logic ol);
    check({tag, "_latency"}, lat, 18);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_value"}, value, v);
    check({tag, "_nz"}, nz_count, nz);
    check({tag, "_not_csd"}, not_csd, nc);
    check({tag, "_err"}, err_code, ec);
    check({tag, "_over"}, over_limit, ol);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_value_hold"}, value, v);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; we = 1'b0; address = '0; dataIn = '0;

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_value", value, 0);
    check("rst_nz", nz_count, 0);
    check("rst_flags", {not_csd, err_code, over_limit}, 0);

    // +1@0, -1@2 -> 1 - 4 = -3
    write_digit(4'd0, 8'h01);
    write_digit(4'd2, 8'hFF);
    run_scan(0, 0, 1'b0, 4'd0, 8'h00);
    check_result("basic", -3, 2, 0, 0, 0);

    // Empty RAM after reset
    do_reset();
    run_scan(0, 0, 1'b0, 4'd0, 8'h00);
    check_result("empty", 0, 0, 0, 0, 0);

    // -1@15, +1@0 -> -32768 + 1
    write_digit(4'd15, 8'hFF);
    write_digit(4'd0, 8'h01);
    run_scan(0, 0, 1'b0, 4'd0, 8'h00);
    check_result("msb", -32767, 2, 0, 0, 0);

    // Adjacent nonzero digits: 8 + 16 = 24
    do_reset();
    write_digit(4'd3, 8'h01);
    write_digit(4'd4, 8'h01);
    run_scan(0, 0, 1'b0, 4'd0, 8'h00);
    check_result("adjacent", 24, 2, 1, 0, 0);

    // Five digits: 1+4+16+64+256 = 341, over the budget of 4
    do_reset();
    for (int i = 0; i < 10; i += 2) write_digit(4'(i), 8'h01);
    run_scan(0, 0, 1'b0, 4'd0, 8'h00);
    check_result("over", 341, 5, 0, 0, 1);

    // Illegal code at 5 counts as zero; +1@1 -> 2
    do_reset();
    write_digit(4'd5, 8'h02);
    write_digit(4'd1, 8'h01);
    run_scan(0, 0, 1'b0, 4'd0, 8'h00);
    check_result("badcode", 2, 1, 0, 1, 0);

    // Repair the digit; err_code must clear on the new scan
    write_digit(4'd5, 8'h00);
    run_scan(0, 0, 1'b0, 4'd0, 8'h00);
    check_result("errclear", 2, 1, 0, 0, 0);

    // we/start pulsed mid-scan are ignored
    run_scan(5, 0, 1'b0, 4'd0, 8'h00);
    check_result("midscan", 2, 1, 0, 0, 0);
    run_scan(0, 0, 1'b0, 4'd0, 8'h00);
    check_result("ram_kept", 2, 1, 0, 0, 0);

    // Write and start in the same idle cycle: scan sees -1@3 -> 2 - 8 = -6
    run_scan(0, 0, 1'b1, 4'd3, 8'hFF);
    check_result("wr_start", -6, 2, 0, 0, 0);

    // Reset mid-scan: value already nonzero before reset lands
    run_scan(0, 9, 1'b0, 4'd0, 8'h00);
    check("midrst_lat", lat, 10);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_value", value, 0);
    check("midrst_nz", nz_count, 0);
    run_scan(0, 0, 1'b0, 4'd0, 8'h00);
    check_result("after_rst", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute guard so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_csd_decoder
`default_nettype wire
